// File: rtl/imgproc_pkg.sv
// Shared definitions for the grayscale -> line buffer -> 3x3 convolution pipeline.
package imgproc_pkg;

  localparam int unsigned ImgWDefault = 640;
  localparam int unsigned ImgHDefault = 480;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun
  } win_state_e;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pos_counter.sv
// Column/row position counters for a raster scan, with enable, clear and wrap flags.
module pos_counter
  import imgproc_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  output logic [cnt_w(IMG_W)-1:0]   col_o,
  output logic [cnt_w(IMG_H)-1:0]   row_o,
  output logic                      col_wrap_o,
  output logic                      row_wrap_o
);

  localparam int unsigned ColW = cnt_w(IMG_W);
  localparam int unsigned RowW = cnt_w(IMG_H);

  logic [ColW-1:0] col_d, col_q;
  logic [RowW-1:0] row_d, row_q;

  assign col_wrap_o = (col_q == ColW'(IMG_W - 1));
  assign row_wrap_o = (row_q == RowW'(IMG_H - 1));
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_wrap_o) begin
        col_d = '0;
        row_d = row_wrap_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 3x3 convolution window: tracks pixel position, drives the
// line-buffer writes/rotation and flags valid window centres, frame completion and truncation.
module conv_window_ctrl
  import imgproc_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iFVAL,
  input  logic                    iDVAL,
  input  logic                    iSW,
  output logic                    oLB_WR,
  output logic [cnt_w(IMG_W)-1:0] oLB_ADDR,
  output logic                    oLB_SHIFT,
  output logic                    oWIN_VAL,
  output logic                    oFILT_SEL,
  output logic                    oFRAME_DONE,
  output logic                    oERR
);

  localparam int unsigned ColW = cnt_w(IMG_W);
  localparam int unsigned RowW = cnt_w(IMG_H);

  win_state_e      state_d, state_q;
  logic            fval_q;
  logic            shift_d, shift_q;
  logic            win_d, win_q;
  logic            filt_d, filt_q;
  logic            done_d, done_q;
  logic            err_d, err_q;
  logic            accept, fval_rise, clr;
  logic            col_wrap, row_wrap;
  logic [ColW-1:0] col;
  logic [RowW-1:0] row;

  pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos_counter (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .en_i       (accept),
    .clr_i      (clr),
    .col_o      (col),
    .row_o      (row),
    .col_wrap_o (col_wrap),
    .row_wrap_o (row_wrap)
  );

  // A pixel arriving with the iFVAL rise is seen in StIdle and therefore never accepted.
  assign accept    = iFVAL & iDVAL & (state_q != StIdle);
  assign fval_rise = iFVAL & ~fval_q;

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    shift_d = accept & col_wrap;
    win_d   = accept & (state_q == StRun) & (col >= ColW'(2));
    unique case (state_q)
      StIdle: begin
        if (fval_rise) begin
          state_d = StFill;
          filt_d  = iSW;
        end
      end
      StFill: begin
        if (!iFVAL) begin
          state_d = StIdle;
          err_d   = 1'b1;
          clr     = 1'b1;
        end else if (accept && col_wrap && row == RowW'(1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!iFVAL) begin
          state_d = StIdle;
          err_d   = 1'b1;
          clr     = 1'b1;
        end else if (accept && col_wrap && row_wrap) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= StIdle;
      fval_q  <= 1'b0;
      shift_q <= 1'b0;
      win_q   <= 1'b0;
      filt_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      shift_q <= shift_d;
      win_q   <= win_d;
      filt_q  <= filt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign oLB_WR      = accept;
  assign oLB_ADDR    = col;
  assign oLB_SHIFT   = shift_q;
  assign oWIN_VAL    = win_q;
  assign oFILT_SEL   = filt_q;
  assign oFRAME_DONE = done_q;
  assign oERR        = err_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on an 8x6 image: full frames, gapped pixels,
// filter latch, truncation, mid-frame reset and ignored pixels.
module tb_conv_window_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned H = 6;
  localparam int unsigned NPix = W * H;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iFVAL = 1'b0;
  logic       iDVAL = 1'b0;
  logic       iSW = 1'b0;
  logic       oLB_WR;
  logic [2:0] oLB_ADDR;
  logic       oLB_SHIFT;
  logic       oWIN_VAL;
  logic       oFILT_SEL;
  logic       oFRAME_DONE;
  logic       oERR;

  int checks = 0;
  int errors = 0;

  // Values captured by step(): combinational ones before the edge, registered ones after it.
  int wr_s, addr_s, shift_s, win_s, filt_s, done_s, err_s;
  int n_win, n_shift, n_done, n_err;

  conv_window_ctrl #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iFVAL       (iFVAL),
    .iDVAL       (iDVAL),
    .iSW         (iSW),
    .oLB_WR      (oLB_WR),
    .oLB_ADDR    (oLB_ADDR),
    .oLB_SHIFT   (oLB_SHIFT),
    .oWIN_VAL    (oWIN_VAL),
    .oFILT_SEL   (oFILT_SEL),
    .oFRAME_DONE (oFRAME_DONE),
    .oERR        (oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic fval, input logic dval, input logic sw, input logic rst);
    @(negedge iCLK);
    iFVAL = fval;
    iDVAL = dval;
    iSW   = sw;
    iRST  = rst;
    #1;
    wr_s   = int'(oLB_WR);
    addr_s = int'(oLB_ADDR);
    @(posedge iCLK);
    #1;
    shift_s = int'(oLB_SHIFT);
    win_s   = int'(oWIN_VAL);
    filt_s  = int'(oFILT_SEL);
    done_s  = int'(oFRAME_DONE);
    err_s   = int'(oERR);
    n_win   += win_s;
    n_shift += shift_s;
    n_done  += done_s;
    n_err   += err_s;
  endtask

  task automatic clear_counts();
    n_win   = 0;
    n_shift = 0;
    n_done  = 0;
    n_err   = 0;
  endtask

  // Raise iFVAL (with a pixel that must be dropped), then send npix pixels; sw0 is presented
  // for the first half of the frame and sw1 afterwards.
  task automatic send_frame(input bit gaps, input bit sw0, input bit sw1, input int npix);
    bit sw;
    step(1'b1, 1'b1, sw0, 1'b0);
    check("rise_wr", wr_s, 0);
    check("rise_filt", filt_s, int'(sw0));
    for (int k = 0; k < npix; k++) begin
      sw = (k < int'(NPix / 2)) ? sw0 : sw1;
      if (gaps) begin
        step(1'b1, 1'b0, sw, 1'b0);
        check("gap_wr", wr_s, 0);
        check("gap_win", win_s, 0);
      end
      step(1'b1, 1'b1, sw, 1'b0);
      check("wr", wr_s, 1);
      check("addr", addr_s, k % int'(W));
      check("win", win_s, int'((k / int'(W)) >= 2 && (k % int'(W)) >= 2));
      check("shift", shift_s, int'((k % int'(W)) == int'(W) - 1));
      check("done", done_s, int'(k == int'(NPix) - 1));
      check("err", err_s, 0);
      check("filt", filt_s, int'(sw0));
    end
  endtask

  initial begin
    clear_counts();
    // Reset state
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_wr", wr_s, 0);
    check("rst_addr", addr_s, 0);
    check("rst_filt", filt_s, 0);
    check("rst_win", win_s, 0);
    check("rst_err", err_s, 0);

    // Pixels with iFVAL low are ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("nofval_wr", wr_s, 0);
    end

    // Full frame, continuous pixels
    clear_counts();
    send_frame(1'b0, 1'b0, 1'b0, int'(NPix));
    check("full_nwin", n_win, 24);
    check("full_nshift", n_shift, 6);
    check("full_ndone", n_done, 1);
    // iFVAL held high after completion must not restart
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("hold_wr", wr_s, 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_nerr", n_err, 0);

    // Same frame with gaps, filter latched 1 while iSW drops mid-frame
    clear_counts();
    send_frame(1'b1, 1'b1, 1'b0, int'(NPix));
    check("gap_nwin", n_win, 24);
    check("gap_nshift", n_shift, 6);
    check("gap_ndone", n_done, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_filt", filt_s, 1);
    check("gap_nerr", n_err, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("new_filt", filt_s, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Truncated frame, fall coincident with a pixel
    clear_counts();
    send_frame(1'b0, 1'b0, 1'b0, 20);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("trunc_wr", wr_s, 0);
    check("trunc_err", err_s, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("trunc_err_once", err_s, 0);
    check("trunc_wr_idle", wr_s, 0);
    check("trunc_nerr", n_err, 1);
    clear_counts();
    send_frame(1'b0, 1'b0, 1'b0, int'(NPix));
    check("after_trunc_nwin", n_win, 24);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset at pixel 30
    clear_counts();
    send_frame(1'b0, 1'b1, 1'b1, 30);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("mrst_filt", filt_s, 0);
    check("mrst_win", win_s, 0);
    check("mrst_shift", shift_s, 0);
    check("mrst_done", done_s, 0);
    check("mrst_err", err_s, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("mrst_wr", wr_s, 0);
    check("mrst_addr", addr_s, 0);
    check("mrst_err2", err_s, 0);
    check("mrst_ndone", n_done, 0);
    clear_counts();
    send_frame(1'b0, 1'b0, 1'b0, int'(NPix));
    check("after_rst_nwin", n_win, 24);
    check("after_rst_ndone", n_done, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("after_rst_nerr", n_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 640: active pixels per line.
REQ-002 Parameter IMG_H, default 480: active lines per frame.
REQ-003 iCLK  input  1  sole clock; all logic rising-edge.
REQ-004 iRST  input  1  reset, synchronous and active-high.
REQ-005 iFVAL  input  1  frame valid from the grayscale stage.
REQ-006 iDVAL  input  1  grayscale pixel valid; one pixel per asserted cycle.
REQ-007 iSW  input  1  filter select switch.
REQ-008 oLB_WR  output  1  line-buffer write enable.
REQ-009 oLB_ADDR  output  clog2(IMG_W)  line-buffer column address.
REQ-010 oLB_SHIFT  output  1  one-cycle pulse: rotate the row buffers at end of line.
REQ-011 oWIN_VAL  output  1  the 3x3 window presented to conv is valid.
REQ-012 oFILT_SEL  output  1  filter select latched per frame.
REQ-013 oFRAME_DONE  output  1  one-cycle pulse on the last accepted pixel of a complete frame.
REQ-014 oERR  output  1  one-cycle pulse when a frame is truncated.

Function
REQ-015 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on accepted pixels (iDVAL=1 in FILL or RUN).
- col wraps to 0 after IMG_W-1 and row increments.
- row wraps to 0 after IMG_H-1.
REQ-016 FSM states SHALL be IDLE, FILL and RUN.
- IDLE->FILL on rising edge of iFVAL.
- FILL->RUN on accepting pixel (row=1, col=IMG_W-1).
- RUN->IDLE on accepting pixel (IMG_H-1, IMG_W-1).
- FILL/RUN->IDLE whenever iFVAL=0.
REQ-017 In IDLE, iDVAL SHALL be ignored: no counter change, all strobes 0.
REQ-018 oLB_WR SHALL equal the accepted-pixel condition combinationally, with oLB_ADDR=col in the same cycle.
REQ-019 oLB_SHIFT SHALL be registered, asserting the cycle after a pixel accepted at col=IMG_W-1, for one cycle.
REQ-020 oWIN_VAL SHALL be registered, asserting the cycle after a pixel accepted in RUN with col>=2.
- Window center is (row-1, col-1).
- Output image is (IMG_W-2)x(IMG_H-2); border centers are never flagged.
REQ-021 oFILT_SEL SHALL capture iSW on the IDLE->FILL transition only, and hold it until the next frame start.
REQ-022 oFRAME_DONE SHALL assert the cycle after the pixel causing RUN->IDLE.
REQ-023 oERR SHALL assert for one cycle when iFVAL falls in FILL or RUN before the frame completes.
- col and row SHALL clear to 0 on that exit.
REQ-024 A rising iFVAL coinciding with iDVAL SHALL NOT accept that pixel; acceptance starts the following cycle.
REQ-025 iFVAL held high after frame completion SHALL NOT restart the frame; a new rising edge is required.
REQ-026 Simultaneous iFVAL fall and iDVAL SHALL drop the pixel and take the error exit.

Reset
REQ-027 On iRST=1 at a clock edge, the block SHALL reset as follows:
- FSM to IDLE; col=0, row=0.
- iFVAL edge-detect register to 0.
- All outputs 0, including oFILT_SEL.
REQ-028 Reset mid-frame SHALL abandon the frame without asserting oERR or oFRAME_DONE; the next frame requires a fresh iFVAL rise.

Structure
REQ-029 Package imgproc_pkg SHALL hold the state enum (IDLE, FILL, RUN) and the default IMG_W/IMG_H constants, shared with the line buffers and conv.
REQ-030 One sub-module, pos_counter, SHALL implement the col/row wrap counters with enable, clear and wrap-flag outputs; the FSM and strobes live in conv_window_ctrl.

Verification
REQ-031 The bench SHALL cover the following directed scenarios, run with IMG_W=8, IMG_H=6:
- Full frame, iDVAL continuous -> 24 oWIN_VAL pulses, 6 oLB_SHIFT pulses, one oFRAME_DONE one cycle after pixel 47, oERR never.
- Same frame with iDVAL toggled every other cycle -> identical pulse counts; oWIN_VAL always one cycle after its pixel.
- iSW=1 at frame start, then iSW=0 mid-frame -> oFILT_SEL stays 1 until the next iFVAL rise.
- iFVAL dropped after 20 pixels -> oERR one pulse, IDLE; the next full frame yields 24 windows.
- iRST asserted at pixel 30 -> all outputs 0 next cycle, no oERR; the next frame is correct.
- iDVAL pulses with iFVAL=0, and iDVAL coincident with the iFVAL rise -> no oLB_WR for those cycles.
